// File: rtl/rv32i_ex_wb.sv
// RV32I execute/writeback back end: ALU, branch resolve, EX->MEM and MEM->WB registers, post-branch squash.
// Optional build macro RV32I_FORWARDING_EN adds MEM/WB operand forwarding; without it raw ID data is used.
module rv32i_ex_wb #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        Clk_100MHz,
  input  logic        Reset,
  input  logic [31:0] ID_PC,
  input  logic        ID_Rd_wr_en,
  input  logic        ID_ALU_source_sel,
  input  logic [3:0]  ID_ALU_op,
  input  logic [31:0] ID_Immediate,
  input  logic        ID_Branch_en,
  input  logic [4:0]  ID_Rd_address,
  input  logic [4:0]  ID_Rs1_address,
  input  logic [4:0]  ID_Rs2_address,
  input  logic [31:0] ID_Rs1_data,
  input  logic [31:0] ID_Rs2_data,
  output logic [31:0] MEM_PC_branch_dest,
  output logic        MEM_PC_source_sel,
  output logic [31:0] MEM_ALU_result,
  output logic [4:0]  WB_Rd_address,
  output logic [31:0] WB_Rd_wr_data,
  output logic        WB_wr_en
);

  // state  | meaning
  // RUN    | sq_cnt == 0, ID instructions execute
  // SQUASH | sq_cnt != 0, ID instructions become bubbles
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  localparam logic [1:0] FLUSH_LD = 2'(FLUSH_CYCLES);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_BLT  = 4'd12;
  localparam logic [3:0] OP_BGE  = 4'd13;
  localparam logic [3:0] OP_BLTU = 4'd14;
  localparam logic [3:0] OP_BGEU = 4'd15;

  logic [0:0]  state_q, state_d;
  logic [1:0]  sq_cnt_q, sq_cnt_d;

  logic        mem_wr_en_q, mem_wr_en_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic [31:0] mem_result_q, mem_result_d;
  logic        mem_sel_q, mem_sel_d;
  logic [31:0] mem_dest_q, mem_dest_d;

  logic        wb_wr_en_q, wb_wr_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic [31:0] rs1_val, rs2_val, op_b, alu_res;
  logic        br_cond, squash, taken;

`ifdef RV32I_FORWARDING_EN
  // MEM is younger than WB, so it is checked first.
  always_comb begin
    rs1_val = ID_Rs1_data;
    if (mem_wr_en_q && (mem_rd_q == ID_Rs1_address) && (ID_Rs1_address != 5'd0))
      rs1_val = mem_result_q;
    else if (wb_wr_en_q && (wb_rd_q == ID_Rs1_address) && (ID_Rs1_address != 5'd0))
      rs1_val = wb_data_q;
  end

  always_comb begin
    rs2_val = ID_Rs2_data;
    if (mem_wr_en_q && (mem_rd_q == ID_Rs2_address) && (ID_Rs2_address != 5'd0))
      rs2_val = mem_result_q;
    else if (wb_wr_en_q && (wb_rd_q == ID_Rs2_address) && (ID_Rs2_address != 5'd0))
      rs2_val = wb_data_q;
  end
`else
  logic [9:0] unused_src_addr;
  assign unused_src_addr = {ID_Rs1_address, ID_Rs2_address};
  assign rs1_val = ID_Rs1_data;
  assign rs2_val = ID_Rs2_data;
`endif

  assign op_b = ID_ALU_source_sel ? ID_Immediate : rs2_val;

  always_comb begin
    alu_res = 32'd0;
    case (ID_ALU_op)
      OP_ADD:  alu_res = rs1_val + op_b;
      OP_SUB:  alu_res = rs1_val - op_b;
      OP_SLL:  alu_res = rs1_val << op_b[4:0];
      OP_SLT:  alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
      OP_SLTU: alu_res = {31'd0, rs1_val < op_b};
      OP_XOR:  alu_res = rs1_val ^ op_b;
      OP_SRL:  alu_res = rs1_val >> op_b[4:0];
      OP_SRA:  alu_res = $signed(rs1_val) >>> op_b[4:0];
      OP_OR:   alu_res = rs1_val | op_b;
      OP_AND:  alu_res = rs1_val & op_b;
      default: alu_res = 32'd0;
    endcase
  end

  // Branch compare ignores the immediate mux: always Rs1 vs Rs2.
  always_comb begin
    br_cond = 1'b0;
    case (ID_ALU_op)
      OP_BEQ:  br_cond = (rs1_val == rs2_val);
      OP_BNE:  br_cond = (rs1_val != rs2_val);
      OP_BLT:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
      OP_BGE:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      OP_BLTU: br_cond = (rs1_val <  rs2_val);
      OP_BGEU: br_cond = (rs1_val >= rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  assign squash = (state_q == SQUASH);
  assign taken  = ID_Branch_en && !squash && br_cond;

  always_comb begin
    mem_wr_en_d  = ID_Rd_wr_en && (ID_Rd_address != 5'd0) && !squash;
    mem_rd_d     = squash ? 5'd0 : ID_Rd_address;
    mem_result_d = squash ? 32'd0 : alu_res;
    mem_sel_d    = taken;
    mem_dest_d   = taken ? (ID_PC + ID_Immediate) : mem_dest_q;

    wb_wr_en_d   = mem_wr_en_q;
    wb_rd_d      = mem_rd_q;
    wb_data_d    = mem_result_q;
  end

  // Only a taken branch seen in RUN reloads the counter; SQUASH just drains it.
  always_comb begin
    sq_cnt_d = sq_cnt_q;
    if (taken)
      sq_cnt_d = FLUSH_LD;
    else if (squash)
      sq_cnt_d = sq_cnt_q - 2'd1;
    state_d = (sq_cnt_d != 2'd0) ? SQUASH : RUN;
  end

  always_ff @(posedge Clk_100MHz) begin
    if (Reset) begin
      state_q      <= RUN;
      sq_cnt_q     <= 2'd0;
      mem_wr_en_q  <= 1'b0;
      mem_rd_q     <= 5'd0;
      mem_result_q <= 32'd0;
      mem_sel_q    <= 1'b0;
      mem_dest_q   <= 32'd0;
      wb_wr_en_q   <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      sq_cnt_q     <= sq_cnt_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_rd_q     <= mem_rd_d;
      mem_result_q <= mem_result_d;
      mem_sel_q    <= mem_sel_d;
      mem_dest_q   <= mem_dest_d;
      wb_wr_en_q   <= wb_wr_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign MEM_PC_branch_dest = mem_dest_q;
  assign MEM_PC_source_sel  = mem_sel_q;
  assign MEM_ALU_result     = mem_result_q;
  assign WB_Rd_address      = wb_rd_q;
  assign WB_Rd_wr_data      = wb_data_q;
  assign WB_wr_en           = wb_wr_en_q;

endmodule

// File: tb/tb_rv32i_ex_wb.sv
// Directed bench for rv32i_ex_wb: reset, ALU sweep, forwarding, branches, squash shadow, reset mid-squash.
module tb_rv32i_ex_wb;
  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] ID_PC;
  logic        ID_Rd_wr_en;
  logic        ID_ALU_source_sel;
  logic [3:0]  ID_ALU_op;
  logic [31:0] ID_Immediate;
  logic        ID_Branch_en;
  logic [4:0]  ID_Rd_address;
  logic [4:0]  ID_Rs1_address;
  logic [4:0]  ID_Rs2_address;
  logic [31:0] ID_Rs1_data;
  logic [31:0] ID_Rs2_data;
  logic [31:0] MEM_PC_branch_dest;
  logic        MEM_PC_source_sel;
  logic [31:0] MEM_ALU_result;
  logic [4:0]  WB_Rd_address;
  logic [31:0] WB_Rd_wr_data;
  logic        WB_wr_en;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv32i_ex_wb dut (
    .Clk_100MHz(clk), .Reset(Reset), .ID_PC(ID_PC), .ID_Rd_wr_en(ID_Rd_wr_en),
    .ID_ALU_source_sel(ID_ALU_source_sel), .ID_ALU_op(ID_ALU_op), .ID_Immediate(ID_Immediate),
    .ID_Branch_en(ID_Branch_en), .ID_Rd_address(ID_Rd_address), .ID_Rs1_address(ID_Rs1_address),
    .ID_Rs2_address(ID_Rs2_address), .ID_Rs1_data(ID_Rs1_data), .ID_Rs2_data(ID_Rs2_data),
    .MEM_PC_branch_dest(MEM_PC_branch_dest), .MEM_PC_source_sel(MEM_PC_source_sel),
    .MEM_ALU_result(MEM_ALU_result), .WB_Rd_address(WB_Rd_address), .WB_Rd_wr_data(WB_Rd_wr_data),
    .WB_wr_en(WB_wr_en)
  );

  task automatic drive(input logic [31:0] pc, input logic wr, input logic src, input logic [3:0] op,
                       input logic [31:0] imm, input logic br, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2);
    ID_PC = pc; ID_Rd_wr_en = wr; ID_ALU_source_sel = src; ID_ALU_op = op; ID_Immediate = imm;
    ID_Branch_en = br; ID_Rd_address = rd; ID_Rs1_address = rs1; ID_Rs2_address = rs2;
    ID_Rs1_data = d1; ID_Rs2_data = d2;
  endtask

  task automatic nop();
    drive(32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    drive($urandom, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, 1'($urandom),
          5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive_random(); tick();
    drive_random(); tick();
    total++; if (MEM_ALU_result !== 32'd0) begin bad++; $display("FAIL rst_mem_result got=%h exp=0", MEM_ALU_result); end
    total++; if (MEM_PC_source_sel !== 1'b0) begin bad++; $display("FAIL rst_pc_sel got=%b exp=0", MEM_PC_source_sel); end
    total++; if (MEM_PC_branch_dest !== 32'd0) begin bad++; $display("FAIL rst_dest got=%h exp=0", MEM_PC_branch_dest); end
    total++; if ({WB_wr_en, WB_Rd_address, WB_Rd_wr_data} !== 38'd0) begin bad++; $display("FAIL rst_wb got=%b/%h/%h exp=0", WB_wr_en, WB_Rd_address, WB_Rd_wr_data); end
    Reset = 1'b0;
    drive_random(); tick();
    total++; if (WB_wr_en !== 1'b0) begin bad++; $display("FAIL rst_release_wb_en got=%b exp=0", WB_wr_en); end
    nop(); tick(); tick(); tick();
  endtask

  task automatic test_alu_sweep();
    logic [31:0] exp_tab [10];
    exp_tab = '{32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 32'h1, 32'h0,
                32'h8000_0001, 32'h4000_0000, 32'hC000_0000, 32'h8000_0001, 32'h0};
    for (int i = 0; i < 10; i++) begin
      drive(32'h0, 1'b1, 1'b1, 4'(i), 32'h1, 1'b0, 5'd10, 5'd1, 5'd2, 32'h8000_0000, 32'h0);
      tick();
      total++; if (MEM_ALU_result !== exp_tab[i]) begin bad++; $display("FAIL alu_mem op=%0d got=%h exp=%h", i, MEM_ALU_result, exp_tab[i]); end
      nop(); tick();
      total++; if ({WB_wr_en, WB_Rd_address, WB_Rd_wr_data} !== {1'b1, 5'd10, exp_tab[i]})
        begin bad++; $display("FAIL alu_wb op=%0d got=%b/%0d/%h exp=1/10/%h", i, WB_wr_en, WB_Rd_address, WB_Rd_wr_data, exp_tab[i]); end
    end
    // SUB from Rs2 wraps; SLL amount taken from low 5 bits; unused code gives 0
    drive(32'h0, 1'b1, 1'b0, 4'd1, 32'h0, 1'b0, 5'd10, 5'd1, 5'd2, 32'h0, 32'h1); tick();
    total++; if (MEM_ALU_result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL alu_sub_wrap got=%h exp=ffffffff", MEM_ALU_result); end
    drive(32'h0, 1'b1, 1'b1, 4'd2, 32'd33, 1'b0, 5'd10, 5'd1, 5'd2, 32'h3, 32'h0); tick();
    total++; if (MEM_ALU_result !== 32'h6) begin bad++; $display("FAIL alu_sll_mask got=%h exp=6", MEM_ALU_result); end
    drive(32'h0, 1'b1, 1'b1, 4'd12, 32'h5, 1'b0, 5'd10, 5'd1, 5'd2, 32'h3, 32'h0); tick();
    total++; if (MEM_ALU_result !== 32'h0) begin bad++; $display("FAIL alu_code12 got=%h exp=0", MEM_ALU_result); end
    drive(32'h0, 1'b1, 1'b1, 4'd0, 32'h5, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    nop(); tick();
    total++; if (WB_wr_en !== 1'b0) begin bad++; $display("FAIL x0_write got=%b exp=0", WB_wr_en); end
    tick();
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_fwd, exp_mw;
`ifdef RV32I_FORWARDING_EN
    exp_fwd = 32'd14; exp_mw = 32'd18;
`else
    exp_fwd = 32'd6;  exp_mw = 32'd6;
`endif
    drive(32'h0, 1'b1, 1'b1, 4'd0, 32'd7, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    drive(32'h0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 5'd6, 5'd5, 5'd5, 32'd3, 32'd3); tick();
    total++; if (MEM_ALU_result !== exp_fwd) begin bad++; $display("FAIL fwd_dist1 got=%h exp=%h", MEM_ALU_result, exp_fwd); end
    nop(); tick();
    total++; if ({WB_wr_en, WB_Rd_address, WB_Rd_wr_data} !== {1'b1, 5'd6, exp_fwd})
      begin bad++; $display("FAIL fwd_dist1_wb got=%b/%0d/%h exp=1/6/%h", WB_wr_en, WB_Rd_address, WB_Rd_wr_data, exp_fwd); end
    drive(32'h0, 1'b1, 1'b1, 4'd0, 32'd7, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    nop(); tick();
    drive(32'h0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 5'd6, 5'd5, 5'd5, 32'd3, 32'd3); tick();
    total++; if (MEM_ALU_result !== exp_fwd) begin bad++; $display("FAIL fwd_dist2 got=%h exp=%h", MEM_ALU_result, exp_fwd); end
    drive(32'h0, 1'b1, 1'b1, 4'd0, 32'd7, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    drive(32'h0, 1'b1, 1'b1, 4'd0, 32'd9, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    drive(32'h0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 5'd6, 5'd5, 5'd5, 32'd3, 32'd3); tick();
    total++; if (MEM_ALU_result !== exp_mw) begin bad++; $display("FAIL fwd_mem_wins got=%h exp=%h", MEM_ALU_result, exp_mw); end
    drive(32'h0, 1'b1, 1'b1, 4'd0, 32'd7, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    drive(32'h0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'd0, 32'd0); tick();
    total++; if (MEM_ALU_result !== 32'd0) begin bad++; $display("FAIL fwd_x0 got=%h exp=0", MEM_ALU_result); end
    nop(); tick(); tick();
  endtask

  task automatic test_branch();
    drive(32'h100, 1'b0, 1'b1, 4'd10, 32'h40, 1'b1, 5'd0, 5'd11, 5'd12, 32'd5, 32'd5); tick();
    total++; if ({MEM_PC_source_sel, MEM_PC_branch_dest} !== {1'b1, 32'h140}) begin bad++; $display("FAIL beq_taken got=%b/%h exp=1/140", MEM_PC_source_sel, MEM_PC_branch_dest); end
    drive(32'h104, 1'b1, 1'b1, 4'd0, 32'd1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    total++; if ({MEM_PC_source_sel, MEM_PC_branch_dest, MEM_ALU_result} !== {1'b0, 32'h140, 32'h0})
      begin bad++; $display("FAIL beq_shadow1 got=%b/%h/%h exp=0/140/0", MEM_PC_source_sel, MEM_PC_branch_dest, MEM_ALU_result); end
    drive(32'h108, 1'b1, 1'b1, 4'd0, 32'd2, 1'b0, 5'd8, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    total++; if ({MEM_ALU_result, WB_wr_en} !== {32'h0, 1'b0}) begin bad++; $display("FAIL beq_shadow2 got=%h/%b exp=0/0", MEM_ALU_result, WB_wr_en); end
    drive(32'h10C, 1'b1, 1'b1, 4'd0, 32'd3, 1'b0, 5'd9, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    total++; if ({MEM_ALU_result, WB_wr_en} !== {32'h3, 1'b0}) begin bad++; $display("FAIL beq_third got=%h/%b exp=3/0", MEM_ALU_result, WB_wr_en); end
    nop(); tick();
    total++; if ({WB_wr_en, WB_Rd_address, WB_Rd_wr_data} !== {1'b1, 5'd9, 32'h3})
      begin bad++; $display("FAIL beq_third_wb got=%b/%0d/%h exp=1/9/3", WB_wr_en, WB_Rd_address, WB_Rd_wr_data); end
    drive(32'h200, 1'b0, 1'b0, 4'd11, 32'h10, 1'b1, 5'd0, 5'd11, 5'd12, 32'd5, 32'd5); tick();
    total++; if ({MEM_PC_source_sel, MEM_PC_branch_dest} !== {1'b0, 32'h140}) begin bad++; $display("FAIL bne_not_taken got=%b/%h exp=0/140", MEM_PC_source_sel, MEM_PC_branch_dest); end
    drive(32'h200, 1'b0, 1'b0, 4'd14, 32'h10, 1'b1, 5'd0, 5'd11, 5'd12, 32'hFFFF_FFFF, 32'd1); tick();
    total++; if (MEM_PC_source_sel !== 1'b0) begin bad++; $display("FAIL bltu_not_taken got=%b exp=0", MEM_PC_source_sel); end
    drive(32'h200, 1'b0, 1'b0, 4'd3, 32'h10, 1'b1, 5'd0, 5'd11, 5'd12, 32'd1, 32'd2); tick();
    total++; if (MEM_PC_source_sel !== 1'b0) begin bad++; $display("FAIL br_code3_not_taken got=%b exp=0", MEM_PC_source_sel); end
    drive(32'h400, 1'b0, 1'b0, 4'd12, 32'h8, 1'b1, 5'd0, 5'd11, 5'd12, 32'hFFFF_FFFF, 32'd1); tick();
    total++; if ({MEM_PC_source_sel, MEM_PC_branch_dest} !== {1'b1, 32'h408}) begin bad++; $display("FAIL blt_taken got=%b/%h exp=1/408", MEM_PC_source_sel, MEM_PC_branch_dest); end
    nop(); tick(); tick(); tick();
  endtask

  task automatic test_shadow();
    drive(32'h200, 1'b0, 1'b0, 4'd10, 32'h10, 1'b1, 5'd0, 5'd11, 5'd12, 32'd4, 32'd4); tick();
    total++; if ({MEM_PC_source_sel, MEM_PC_branch_dest} !== {1'b1, 32'h210}) begin bad++; $display("FAIL shadow_first got=%b/%h exp=1/210", MEM_PC_source_sel, MEM_PC_branch_dest); end
    drive(32'h300, 1'b0, 1'b0, 4'd11, 32'h20, 1'b1, 5'd0, 5'd11, 5'd12, 32'd1, 32'd2); tick();
    total++; if ({MEM_PC_source_sel, MEM_PC_branch_dest} !== {1'b0, 32'h210}) begin bad++; $display("FAIL shadow_bne got=%b/%h exp=0/210", MEM_PC_source_sel, MEM_PC_branch_dest); end
    nop(); tick();
    total++; if (MEM_PC_source_sel !== 1'b0) begin bad++; $display("FAIL shadow_t2 got=%b exp=0", MEM_PC_source_sel); end
    drive(32'h0, 1'b1, 1'b1, 4'd0, 32'd5, 1'b0, 5'd8, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    total++; if (MEM_ALU_result !== 32'd5) begin bad++; $display("FAIL shadow_no_reload got=%h exp=5", MEM_ALU_result); end
    nop(); tick();
    total++; if ({WB_wr_en, WB_Rd_address, WB_Rd_wr_data} !== {1'b1, 5'd8, 32'd5})
      begin bad++; $display("FAIL shadow_wb got=%b/%0d/%h exp=1/8/5", WB_wr_en, WB_Rd_address, WB_Rd_wr_data); end
    tick();
  endtask

  task automatic test_reset_mid_squash();
    drive(32'h500, 1'b0, 1'b0, 4'd10, 32'h20, 1'b1, 5'd0, 5'd11, 5'd12, 32'd1, 32'd1); tick();
    total++; if (MEM_PC_source_sel !== 1'b1) begin bad++; $display("FAIL mid_rst_branch got=%b exp=1", MEM_PC_source_sel); end
    Reset = 1'b1;
    drive(32'h0, 1'b1, 1'b1, 4'd0, 32'd9, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    total++; if ({MEM_PC_source_sel, MEM_PC_branch_dest, MEM_ALU_result} !== 65'd0)
      begin bad++; $display("FAIL mid_rst_clear got=%b/%h/%h exp=0/0/0", MEM_PC_source_sel, MEM_PC_branch_dest, MEM_ALU_result); end
    Reset = 1'b0;
    drive(32'h0, 1'b1, 1'b1, 4'd0, 32'h21, 1'b0, 5'd9, 5'd0, 5'd0, 32'h0, 32'h0); tick();
    total++; if (MEM_ALU_result !== 32'h21) begin bad++; $display("FAIL mid_rst_first got=%h exp=21", MEM_ALU_result); end
    nop(); tick();
    total++; if ({WB_wr_en, WB_Rd_address, WB_Rd_wr_data} !== {1'b1, 5'd9, 32'h21})
      begin bad++; $display("FAIL mid_rst_wb got=%b/%0d/%h exp=1/9/21", WB_wr_en, WB_Rd_address, WB_Rd_wr_data); end
  endtask

  initial begin
    Reset = 1'b1;
    nop();
    test_reset();
    test_alu_sweep();
    test_forwarding();
    test_branch();
    test_shadow();
    test_reset_mid_squash();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
